// File: rtl/pool_pkg.sv
// Shared pooling definitions: default pixel width and an unsigned max helper
// reused by the OFM post-processing stages.
package pool_pkg;

  localparam int DATA_W = 13;

  // Pure selection: no width growth, and equal operands give the same result
  function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row buffer holding the horizontal pair maxima of the even row.
// One synchronous write port, one asynchronous read port, no reset on storage.
module pool_line_buf #(
  parameter int DEPTH  = 4,
  parameter int AW     = 2,
  parameter int DATA_W = 13
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ofm_maxpool.sv
// 2x2 stride-2 max pooling over a serial row-major OFM stream.
// One cycle from the bottom-right beat of a window to out_valid; no backpressure.
module ofm_maxpool
  import pool_pkg::*;
#(
  parameter int DATA_W = pool_pkg::DATA_W,
  parameter int MAP_W  = 8,
  parameter int MAP_H  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_done
);

  localparam int CW   = (MAP_W > 2) ? $clog2(MAP_W) : 1;
  localparam int RW   = (MAP_H > 2) ? $clog2(MAP_H) : 1;
  localparam int LB_D = MAP_W / 2;
  localparam int AW   = (LB_D > 2) ? $clog2(LB_D) : 1;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] pair_max;
  logic [DATA_W-1:0] h;
  logic [DATA_W-1:0] lb_rdata;
  logic [AW-1:0]     lb_addr;
  logic              lb_we;
  logic              last_col;
  logic              last_row;

  assign last_col = (col == CW'(MAP_W - 1));
  assign last_row = (row == RW'(MAP_H - 1));
  assign h        = max_u(pair_max, in_data);
  assign lb_addr  = AW'(col >> 1);
  // Even rows park their pair maxima; odd rows read them back at the same slot
  assign lb_we    = in_valid & col[0] & ~row[0];

  pool_line_buf #(
    .DEPTH  (LB_D),
    .AW     (AW),
    .DATA_W (DATA_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (h),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      pair_max   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (!col[0]) begin
          pair_max <= in_data;
        end else if (row[0]) begin
          out_data   <= max_u(lb_rdata, h);
          out_valid  <= 1'b1;
          frame_done <= last_col & last_row;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule
